// File: rtl/lcd_cmd_seq.sv
// Command sequencer in front of the LCD controller: queues host opcodes in a
// small FIFO and issues them one at a time under the busy/done handshake.
module lcd_cmd_seq #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] host_cmd,
   input  logic       host_valid,
   output logic       host_ready,
   output logic [3:0] cmd,
   output logic       cmd_valid,
   input  logic       busy,
   input  logic       done,
   output logic       seq_idle,
   output logic [7:0] frame_cnt,
   output logic [7:0] illegal_cnt,
   output logic       timeout_err
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_REL} state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic [3:0]      r_mem [FIFO_DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [3:0]      r_cmd;
   logic [TW-1:0]   r_timer;
   logic            r_done_seen;
   logic [7:0]      r_frame_cnt;
   logic [7:0]      r_illegal_cnt;
   logic            r_timeout_err;

   logic            w_push;
   logic            w_pop;
   logic            w_empty;
   logic [3:0]      w_head;
   logic [TW-1:0]   w_timer_nx;
   logic            w_load_cmd;
   logic            w_illegal;
   logic            w_set_terr;
   logic            w_frame_inc;

   assign host_ready  = (r_count != CW'(FIFO_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_push      = host_valid && host_ready;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_timer_nx  = r_timer + TW'(1);
   assign cmd         = r_cmd;
   assign cmd_valid   = (r_state == S_ISSUE);
   assign seq_idle    = w_empty && (r_state == S_IDLE);
   assign frame_cnt   = r_frame_cnt;
   assign illegal_cnt = r_illegal_cnt;
   assign timeout_err = r_timeout_err;

   always_comb begin
      w_state_nx  = r_state;
      w_pop       = 1'b0;
      w_load_cmd  = 1'b0;
      w_illegal   = 1'b0;
      w_set_terr  = 1'b0;
      w_frame_inc = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && !busy) begin
               w_pop = 1'b1;
               if (w_head >= 4'd12) begin
                  w_illegal = 1'b1;
               end else begin
                  w_load_cmd = 1'b1;
                  w_state_nx = S_ISSUE;
               end
            end
         end
         S_ISSUE: w_state_nx = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (busy) begin
               w_state_nx = S_WAIT_REL;
            end else if (w_timer_nx == TW'(ACK_TIMEOUT)) begin
               w_set_terr = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         S_WAIT_REL: begin
            // A Write only counts if done arrived at or before busy release.
            if (!busy) begin
               w_state_nx = S_IDLE;
               if (r_cmd == 4'd0) begin
                  if (r_done_seen || done) w_frame_inc = 1'b1;
                  else                     w_set_terr  = 1'b1;
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= host_cmd;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_cmd         <= '0;
         r_timer       <= '0;
         r_done_seen   <= 1'b0;
         r_frame_cnt   <= '0;
         r_illegal_cnt <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_load_cmd) r_cmd <= w_head;
         if (r_state == S_ISSUE) begin
            r_timer     <= '0;
            r_done_seen <= 1'b0;
         end else if (r_state == S_WAIT_ACK && !busy) begin
            r_timer <= w_timer_nx;
         end else if (r_state == S_WAIT_REL && done) begin
            r_done_seen <= 1'b1;
         end
         if (w_illegal && r_illegal_cnt != 8'hFF) r_illegal_cnt <= r_illegal_cnt + 8'd1;
         if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 8'd1;
         if (w_set_terr)  r_timeout_err <= 1'b1;
      end
   end
endmodule

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
- Command sequencer directly upstream of the LCD controller.
- Buffers host-issued 4-bit LCD commands in a small FIFO and issues them one at a time on cmd/cmd_valid.
- Obeys the controller's busy/done handshake; drops illegal opcodes and counts completed frame writes.

Parameters:
FIFO_DEPTH, 8, command FIFO entries (power of two, 2..16)
ACK_TIMEOUT, 15, max cycles to wait for busy to rise after cmd_valid before abandoning the command

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset)
host_cmd  input  4  command opcode from host
host_valid  input  1  host push strobe
host_ready  output  1  FIFO can accept (not full)
cmd  output  4  opcode to LCD controller
cmd_valid  output  1  one-cycle issue strobe to LCD controller
busy  input  1  LCD controller busy
done  input  1  LCD controller frame-write complete pulse
seq_idle  output  1  FIFO empty and FSM in IDLE
frame_cnt  output  8  completed Write commands, wraps 255->0
illegal_cnt  output  8  dropped opcodes 12..15, saturates at 255
timeout_err  output  1  sticky: an issued command was never acknowledged

Behaviour:
- Reset (reset=0, async): FIFO flushed; FSM=IDLE; cmd=0, cmd_valid=0, frame_cnt=0, illegal_cnt=0, timeout_err=0; host_ready=1, seq_idle=1 (both combinational from state/count).
- FIFO: push when host_valid && host_ready; host_ready = (count != FIFO_DEPTH), so a push on a full FIFO is never accepted, even with a same-cycle pop. Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged. Push into an empty FIFO is not visible to the pop logic until the next cycle. Pointers wrap modulo FIFO_DEPTH.
- Legal opcodes: 0..11; 0 = Write.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_REL.
- IDLE: when FIFO non-empty && busy==0, pop head.
  - Opcode 12..15: discard; illegal_cnt++ (saturating); stay in IDLE. The next pop can occur the following cycle.
  - Legal opcode: register it into cmd; go to ISSUE.
- ISSUE: cmd_valid=1 for exactly this cycle; cmd holds the opcode; go to WAIT_ACK with timer=0.
- cmd stays stable from ISSUE until the next ISSUE.
- WAIT_ACK:
  - busy==1: go to WAIT_REL.
  - Otherwise timer++. When timer reaches ACK_TIMEOUT: set timeout_err, go to IDLE (command abandoned).
- WAIT_REL: wait for busy==0.
  - Non-Write: go to IDLE.
  - Write: a done pulse must be seen in WAIT_REL (it may coincide with busy falling). On busy==0, frame_cnt++ if done was seen, then go to IDLE. If busy falls without done, return to IDLE and set timeout_err.
- Issue latency: pop at cycle T, cmd_valid at T+1. At most one command outstanding.
- While busy is high after reset (image load), nothing issues; commands accumulate in the FIFO.
- done outside WAIT_REL: ignored.
- cmd_valid is never asserted while busy==1 was sampled in the pop cycle.
- Reset asserted mid-operation: immediate return to reset values; queued commands are lost.

Test Plan:
- Hold busy=1 for 70 cycles after reset; push 1,5,0. -> FIFO count 3, cmd_valid stays 0. After busy falls: three single-cycle cmd_valid pulses, cmd=1, 5, 0 in order. frame_cnt=1 after the done pulse.
- Push 9 opcodes (FIFO_DEPTH=8) back-to-back with busy=1. -> host_ready low after the 8th push; 9th not accepted; 8 commands issued in order once busy=0.
- Push 13, 3, 15. -> illegal_cnt=2; only cmd=3 issued; no cmd_valid for 13 or 15.
- Model keeps busy=0 after an issue. -> after 15 cycles in WAIT_ACK, timeout_err=1; FSM returns to IDLE and issues the next queued command.
- Model busy responds 1 cycle after cmd_valid and lasts 2 cycles (Shift) or 66 cycles with done (Write). -> next cmd_valid no earlier than 1 cycle after busy falls; frame_cnt increments per Write, wrapping 255->0 after 256 writes.
- Assert reset=0 while in WAIT_REL with 4 queued commands. -> all outputs at reset values, seq_idle=1; after release, no cmd_valid until new pushes.
